memory_dumper: RTL and testbench
================================

# memory_dumper

Streams a block of memory words out over the UART transmit byte interface: a 4-byte little-endian length header, then each word little-endian. It is the transmit-side counterpart of the boot loading path and is used to read back instruction or data memory for host-side verification and debug. It sits between a memory read port and the UART transmitter, and is triggered by a single `start` pulse.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserted at 0.
- `start`  in  1  one-cycle request to begin a dump. Sampled only in IDLE or DONE.
- `base_addr`  in  32  byte address of the first word. Captured on an accepted `start`.
- `byte_size`  in  32  dump length in bytes. Captured on an accepted `start`; bits [1:0] are cleared on capture.
- `busy`  out  1  high in SEND_SIZE, FETCH and SEND_WORD.
- `completed`  out  1  high in DONE.
- `mem_out_addr`  out  32  read address; stable while `mem_out_valid` is high.
- `mem_out_valid`  out  1  read request.
- `mem_out_data`  in  32  read data; valid in the cycle where `mem_out_valid && mem_out_ready`.
- `mem_out_ready`  in  1  read completion.
- `uart_in_data`  out  8  byte to transmit; stable while `uart_in_valid` is high.
- `uart_in_valid`  out  1  byte offered to the UART.
- `uart_in_ready`  in  1  UART accepts the byte when `uart_in_valid && uart_in_ready`.

## Operation
States:
- IDLE: the reset state.
- SEND_SIZE: sends the 4 bytes of the captured size, LSB first.
- FETCH: holds the memory read request until it completes.
- SEND_WORD: sends the 4 bytes of the fetched word, LSB first.
- DONE: finished; waits for a new `start`.

Registers:
- `size_q`: `byte_size & ~3`, captured on an accepted `start`.
- `addr_q`: next read address; loaded with `base_addr` on an accepted `start`.
- `remaining_q`: words still to fetch; loaded with `size_q >> 2`.
- `word_q`: latched read data.
- `byte_idx`: 2-bit byte index within the current word; reset to 0 on entering SEND_SIZE and on entering SEND_WORD.

Transitions:
- IDLE or DONE, `start` = 1 -> SEND_SIZE. Registers are captured and `uart_in_valid` is set.
- SEND_SIZE, byte accepted with `byte_idx` = 3:
  - if `remaining_q` ≠ 0 -> FETCH;
  - otherwise -> DONE.
- FETCH, `mem_out_ready` = 1 -> SEND_WORD. `word_q` ← `mem_out_data`; `addr_q` += 4 (wraps mod 2^32); `remaining_q` −= 1.
- SEND_WORD, byte accepted with `byte_idx` = 3:
  - if `remaining_q` ≠ 0 -> FETCH;
  - otherwise -> DONE.
- On each byte accepted with `byte_idx` < 3: `byte_idx` += 1.

Output rules:
- `uart_in_data` = byte `byte_idx` of `size_q` (in SEND_SIZE) or of `word_q` (in SEND_WORD).
- `start` while `busy` is ignored. Captured values are not affected by input changes mid-dump.

## Timing
- Reset (async, `reset` = 0): immediately all outputs are 0, state is IDLE, and all counters are 0. Reset mid-transfer drops the transfer; the next dump restarts from the header.
- All outputs are registered.
- `start` accepted at edge N: from cycle N+1, `uart_in_valid` = 1 with `uart_in_data` = `size_q[7:0]`.
- Byte transfer:
  - one byte per cycle while `uart_in_ready` stays high;
  - `uart_in_data` and `uart_in_valid` are held while `uart_in_ready` = 0.
- After the 4th byte is accepted, `uart_in_valid` is 0 in the following cycle.
- In FETCH:
  - `mem_out_valid` = 1 and `mem_out_addr` = `addr_q` for as long as needed;
  - the cycle after `mem_out_ready`, `mem_out_valid` = 0 and `uart_in_valid` = 1 with byte 0 of `word_q`.
- With memory and UART always ready, each word takes 5 cycles: 1 fetch + 4 bytes.
- `completed` rises the cycle after the final byte is accepted and stays high until the next accepted `start` or reset.
- `byte_size` < 4 gives a header of 0x00000000 and no reads.

## Test plan
- Zero-length dump: `byte_size`=2, `start` -> bytes 00 00 00 00; no `mem_out_valid`; `completed` = 1 five cycles after `start`.
- Basic dump: `base_addr`=0x100, `byte_size`=8, memory returns 0x11223344 and 0xAABBCCDD, all ready -> read addresses 0x100 then 0x104; UART bytes 08 00 00 00 44 33 22 11 DD CC BB AA.
- Backpressure: `uart_in_ready` toggled randomly and `mem_out_ready` delayed 3 cycles -> identical byte stream; data and address stable during stalls; no duplicated or dropped bytes.
- Address wrap: `base_addr`=0xFFFFFFFC, `byte_size`=8 -> read addresses 0xFFFFFFFC then 0x00000000.
- Busy start: pulse `start` with new inputs during SEND_WORD -> ignored; the original dump completes unchanged. A `start` in DONE then runs a new dump.
- Async reset: assert `reset` low mid-SEND_WORD, off the clock edge -> `uart_in_valid`, `mem_out_valid`, `busy` and `completed` go to 0 immediately; after release, state is IDLE.

Source files
------------

// File: rtl/memory_dumper_if.sv
// memory_dumper_if
//   Bundles the two handshake buses of the memory dumper:
//     - memory read port : mem_out_addr/mem_out_valid (request),
//                          mem_out_data/mem_out_ready (completion)
//     - UART transmit    : uart_in_data/uart_in_valid (offer),
//                          uart_in_ready (accept)
//   master : the dumper side (drives requests and bytes)
//   slave  : the memory / UART side (drives data and ready)
interface memory_dumper_if;
  logic [31:0] mem_out_addr;
  logic        mem_out_valid;
  logic [31:0] mem_out_data;
  logic        mem_out_ready;
  logic [7:0]  uart_in_data;
  logic        uart_in_valid;
  logic        uart_in_ready;

  modport master (
    output mem_out_addr,
    output mem_out_valid,
    input  mem_out_data,
    input  mem_out_ready,
    output uart_in_data,
    output uart_in_valid,
    input  uart_in_ready
  );

  modport slave (
    input  mem_out_addr,
    input  mem_out_valid,
    output mem_out_data,
    output mem_out_ready,
    input  uart_in_data,
    input  uart_in_valid,
    output uart_in_ready
  );
endinterface

// File: rtl/memory_dumper.sv
// memory_dumper
//   Streams a block of memory words out over the UART transmit byte
//   interface: a 4-byte little-endian length header, then every word
//   little-endian. Triggered by a one-cycle start pulse.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin a dump (sampled only in IDLE/DONE)
//   base_addr  in   byte address of first word (captured on start)
//   byte_size  in   dump length in bytes, bits [1:0] ignored
//   busy       out  transfer in progress
//   completed  out  dump finished, held until next start or reset
//   bus        master side of the memory read port and UART tx port
module memory_dumper (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [31:0]        byte_size,
  output logic               busy,
  output logic               completed,
  memory_dumper_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_SIZE,
    S_FETCH,
    S_SEND_WORD,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_size;
  logic [31:0] r_addr;
  logic [31:0] r_rem;
  logic [31:0] r_word;
  logic [1:0]  r_idx;

  logic [31:0] w_size_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_word_nxt;
  logic [1:0]  w_idx_nxt;

  logic        r_busy;
  logic        r_completed;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic        r_uart_valid;
  logic [7:0]  r_uart_data;

  logic        w_busy_nxt;
  logic        w_completed_nxt;
  logic        w_mem_valid_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic        w_uart_valid_nxt;
  logic [7:0]  w_uart_data_nxt;

  logic        w_byte_acc;
  logic [31:0] w_size_cap;

  assign w_byte_acc = r_uart_valid & bus.uart_in_ready;
  assign w_size_cap = byte_size & 32'hFFFF_FFFC;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt = r_state;
    w_size_nxt  = r_size;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_word_nxt  = r_word;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_SEND_SIZE;
          w_size_nxt  = w_size_cap;
          w_addr_nxt  = base_addr;
          w_rem_nxt   = w_size_cap >> 2;
          w_idx_nxt   = '0;
        end
      end
      S_SEND_SIZE, S_SEND_WORD: begin
        if (w_byte_acc) begin
          // 2-bit index wraps 3->0, so it is already cleared on leaving
          w_idx_nxt = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_state_nxt = (r_rem != '0) ? S_FETCH : S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (bus.mem_out_ready) begin
          w_state_nxt = S_SEND_WORD;
          w_word_nxt  = bus.mem_out_data;
          w_addr_nxt  = r_addr + 32'd4;
          w_rem_nxt   = r_rem - 32'd1;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    w_busy_nxt       = 1'b0;
    w_completed_nxt  = 1'b0;
    w_mem_valid_nxt  = 1'b0;
    w_mem_addr_nxt   = '0;
    w_uart_valid_nxt = 1'b0;
    w_uart_data_nxt  = '0;
    case (w_state_nxt)
      S_SEND_SIZE: begin
        w_busy_nxt       = 1'b1;
        w_uart_valid_nxt = 1'b1;
        case (w_idx_nxt)
          2'd0:    w_uart_data_nxt = w_size_nxt[7:0];
          2'd1:    w_uart_data_nxt = w_size_nxt[15:8];
          2'd2:    w_uart_data_nxt = w_size_nxt[23:16];
          default: w_uart_data_nxt = w_size_nxt[31:24];
        endcase
      end
      S_FETCH: begin
        w_busy_nxt      = 1'b1;
        w_mem_valid_nxt = 1'b1;
        w_mem_addr_nxt  = w_addr_nxt;
      end
      S_SEND_WORD: begin
        w_busy_nxt       = 1'b1;
        w_uart_valid_nxt = 1'b1;
        case (w_idx_nxt)
          2'd0:    w_uart_data_nxt = w_word_nxt[7:0];
          2'd1:    w_uart_data_nxt = w_word_nxt[15:8];
          2'd2:    w_uart_data_nxt = w_word_nxt[23:16];
          default: w_uart_data_nxt = w_word_nxt[31:24];
        endcase
      end
      S_DONE: begin
        w_completed_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_size       <= '0;
      r_addr       <= '0;
      r_rem        <= '0;
      r_word       <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_completed  <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_addr   <= '0;
      r_uart_valid <= 1'b0;
      r_uart_data  <= '0;
    end else begin
      r_size       <= w_size_nxt;
      r_addr       <= w_addr_nxt;
      r_rem        <= w_rem_nxt;
      r_word       <= w_word_nxt;
      r_idx        <= w_idx_nxt;
      r_busy       <= w_busy_nxt;
      r_completed  <= w_completed_nxt;
      r_mem_valid  <= w_mem_valid_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_uart_valid <= w_uart_valid_nxt;
      r_uart_data  <= w_uart_data_nxt;
    end
  end

  assign busy              = r_busy;
  assign completed         = r_completed;
  assign bus.mem_out_valid = r_mem_valid;
  assign bus.mem_out_addr  = r_mem_addr;
  assign bus.uart_in_valid = r_uart_valid;
  assign bus.uart_in_data  = r_uart_data;

endmodule

// File: tb/tb_memory_dumper.sv
// tb_memory_dumper
//   Directed bench for memory_dumper: drives start pulses, acts as the
//   memory and UART partners, and compares captured byte streams and read
//   addresses against hand-computed vectors.
module tb_memory_dumper;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] byte_size;
  logic        busy;
  logic        completed;

  memory_dumper_if bus();

  memory_dumper dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .byte_size (byte_size),
    .busy      (busy),
    .completed (completed),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [7:0]  exp_b[$];
  logic [31:0] exp_a[$];
  logic [31:0] rd_w[$];
  logic [7:0]  got_b[$];
  logic [31:0] got_a[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one dump with this bench acting as memory and UART.
  // delay: cycles the memory withholds ready; rnd: random UART stalls;
  // inject_at: cycle at which a conflicting start is pulsed (0 = never);
  // exp_cycles: expected negedge count until completed (0 = unchecked).
  task automatic run_dump(input string name, input logic [31:0] base, input logic [31:0] size,
                          input int unsigned delay, input bit rnd,
                          input int unsigned inject_at, input int unsigned exp_cycles);
    int unsigned cyc;
    int unsigned wt;
    int unsigned nrd;
    int unsigned viol;
    bit          done;
    logic        p_uv, p_ur, p_mv, p_mr;
    logic [7:0]  p_ud;
    logic [31:0] p_ma;
    got_b.delete();
    got_a.delete();
    cyc = 0; wt = 0; nrd = 0; viol = 0; done = 1'b0;
    p_uv = 1'b0; p_ur = 1'b0; p_mv = 1'b0; p_mr = 1'b0; p_ud = '0; p_ma = '0;
    @(negedge clk);
    base_addr = base;
    byte_size = size;
    start     = 1'b1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (completed) begin
        done = 1'b1;
      end else begin
        if (cyc == inject_at) begin
          chk({name, " busy at inject"}, {31'd0, busy}, 32'd1);
          start     = 1'b1;
          base_addr = 32'h0000_0300;
          byte_size = 32'd16;
        end
        if (p_uv && !p_ur) begin
          if (!bus.uart_in_valid || bus.uart_in_data !== p_ud) viol++;
        end
        if (p_mv && !p_mr) begin
          if (!bus.mem_out_valid || bus.mem_out_addr !== p_ma) viol++;
        end
        bus.uart_in_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.uart_in_valid && bus.uart_in_ready) got_b.push_back(bus.uart_in_data);
        if (bus.mem_out_valid) begin
          if (wt >= delay) begin
            bus.mem_out_ready = 1'b1;
            bus.mem_out_data  = (nrd < rd_w.size()) ? rd_w[nrd] : 32'h0;
            got_a.push_back(bus.mem_out_addr);
            nrd++;
            wt = 0;
          end else begin
            bus.mem_out_ready = 1'b0;
            wt++;
          end
        end else begin
          bus.mem_out_ready = 1'b0;
        end
        p_uv = bus.uart_in_valid; p_ur = bus.uart_in_ready; p_ud = bus.uart_in_data;
        p_mv = bus.mem_out_valid; p_mr = bus.mem_out_ready; p_ma = bus.mem_out_addr;
      end
    end
    bus.uart_in_ready = 1'b1;
    bus.mem_out_ready = 1'b0;
    chk({name, " finished in budget"}, {31'd0, done}, 32'd1);
    if (exp_cycles != 0) chk({name, " cycles to completed"}, cyc, exp_cycles);
    chk({name, " busy after done"}, {31'd0, busy}, 32'd0);
    chk({name, " stall stability violations"}, viol, 32'd0);
    chk({name, " byte count"}, got_b.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      chk($sformatf("%s byte%0d", name, i), {24'd0, got_b[i]}, {24'd0, exp_b[i]});
    chk({name, " read count"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      chk($sformatf("%s addr%0d", name, i), got_a[i], exp_a[i]);
  endtask

  initial begin
    reset             = 1'b0;
    start             = 1'b0;
    base_addr         = '0;
    byte_size         = '0;
    bus.mem_out_data  = '0;
    bus.mem_out_ready = 1'b0;
    bus.uart_in_ready = 1'b1;
    #2;
    chk("reset busy",       {31'd0, busy},              32'd0);
    chk("reset completed",  {31'd0, completed},         32'd0);
    chk("reset uart_valid", {31'd0, bus.uart_in_valid}, 32'd0);
    chk("reset mem_valid",  {31'd0, bus.mem_out_valid}, 32'd0);
    chk("reset mem_addr",   bus.mem_out_addr,           32'd0);
    chk("reset uart_data",  {24'd0, bus.uart_in_data},  32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Zero-length dump: size 2 -> header 0, no reads, completed on cycle 5
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h00};
    exp_a = {};
    rd_w  = {};
    run_dump("zero", 32'h0000_0040, 32'd2, 0, 1'b0, 0, 5);
    chk("zero completed", {31'd0, completed}, 32'd1);

    // Basic two-word dump
    exp_b = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
              8'hDD, 8'hCC, 8'hBB, 8'hAA};
    exp_a = '{32'h0000_0100, 32'h0000_0104};
    rd_w  = '{32'h1122_3344, 32'hAABB_CCDD};
    run_dump("basic", 32'h0000_0100, 32'd8, 0, 1'b0, 0, 15);

    // Same dump under memory delay and random UART stalls
    run_dump("backpressure", 32'h0000_0100, 32'd8, 3, 1'b1, 0, 0);

    // Address wrap
    exp_b = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01,
              8'h08, 8'h07, 8'h06, 8'h05};
    exp_a = '{32'hFFFF_FFFC, 32'h0000_0000};
    rd_w  = '{32'h0102_0304, 32'h0506_0708};
    run_dump("wrap", 32'hFFFF_FFFC, 32'd8, 0, 1'b0, 0, 15);

    // Start pulsed during SEND_WORD is ignored
    exp_b = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_a = '{32'h0000_0200};
    rd_w  = '{32'hDEAD_BEEF};
    run_dump("busystart", 32'h0000_0200, 32'd4, 0, 1'b0, 7, 10);

    // New dump from DONE; size 5 is truncated to one word
    exp_b = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    exp_a = '{32'h0000_0300};
    rd_w  = '{32'hCAFE_F00D};
    run_dump("fromdone", 32'h0000_0300, 32'd5, 0, 1'b0, 0, 10);

    // Asynchronous reset during SEND_WORD
    @(negedge clk);
    base_addr        = 32'h0000_0400;
    byte_size        = 32'd8;
    start            = 1'b1;
    bus.mem_out_data = 32'h5566_7788;
    repeat (7) begin
      @(negedge clk);
      start             = 1'b0;
      bus.mem_out_ready = bus.mem_out_valid;
    end
    chk("pre-reset busy",       {31'd0, busy},              32'd1);
    chk("pre-reset uart_valid", {31'd0, bus.uart_in_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset uart_valid", {31'd0, bus.uart_in_valid}, 32'd0);
    chk("async reset mem_valid",  {31'd0, bus.mem_out_valid}, 32'd0);
    chk("async reset busy",       {31'd0, busy},              32'd0);
    chk("async reset completed",  {31'd0, completed},         32'd0);
    @(negedge clk);
    reset             = 1'b1;
    bus.mem_out_ready = 1'b0;
    @(negedge clk);
    chk("post-reset busy",       {31'd0, busy},              32'd0);
    chk("post-reset completed",  {31'd0, completed},         32'd0);
    chk("post-reset uart_valid", {31'd0, bus.uart_in_valid}, 32'd0);

    // Dump after reset restarts from the header
    exp_b = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    exp_a = '{32'h0000_0400};
    rd_w  = '{32'h1234_5678};
    run_dump("afterreset", 32'h0000_0400, 32'd4, 0, 1'b0, 0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
